// File: rtl/alu_sched_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for alu_op_scheduler.
package alu_sched_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return (op != 3'b011) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// Two-input round-robin arbiter; ptr holds the last-granted requester.
module alu_sched_arb (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       next_ptr
);

    always_comb begin
        if (valid == 2'b11) begin
            grant = ptr ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
        next_ptr = accept ? grant[1] : ptr;
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one logical/iterative-shift unit between two requesters with round-robin arbitration.
// Optional ALU_SCHED_ERR_EN adds resp_err and fast-paths illegal opcodes straight to RESP.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out,
`ifdef ALU_SCHED_ERR_EN
    output logic             resp_err,
`endif
    output logic             busy
);

    state_t             state;
    logic               ptr;
    logic [2:0]         op;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   opb;
    logic [SHAMT_W-1:0] cnt;

    logic [1:0]         grant;
    logic               accept;
    logic               next_ptr;
    logic               idle;
    logic [2:0]         sel_op;
    logic [WIDTH-1:0]   sel_in1;
    logic [WIDTH-1:0]   sel_in2;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   shift_nxt;

    alu_sched_arb u_arb (
        .valid    ({req1_valid, req0_valid}),
        .ptr      (ptr),
        .accept   (accept),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // Ready is masked during reset so no request is ever seen as accepted then.
    assign idle       = (state == IDLE) && !rst;
    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];
    assign accept     = req0_ready || req1_ready;

    assign sel_op  = grant[1] ? req1_sel : req0_sel;
    assign sel_in1 = grant[1] ? req1_in1 : req0_in1;
    assign sel_in2 = grant[1] ? req1_in2 : req0_in2;

    always_comb begin
        case (op)
            OP_AND:  logic_res = acc & opb;
            OP_OR:   logic_res = acc | opb;
            OP_XOR:  logic_res = acc ^ opb;
            default: logic_res = '0;
        endcase
        case (op)
            OP_SLL:  shift_nxt = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_nxt = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  shift_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: shift_nxt = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b1;
            op         <= OP_AND;
            acc        <= '0;
            opb        <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_out   <= '0;
            busy       <= 1'b0;
`ifdef ALU_SCHED_ERR_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            ptr <= next_ptr;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= sel_op;
                        acc     <= sel_in1;
                        opb     <= sel_in2;
                        cnt     <= sel_in2[SHAMT_W-1:0];
                        resp_id <= grant[1];
                        busy    <= 1'b1;
`ifdef ALU_SCHED_ERR_EN
                        resp_err <= !is_legal(sel_op);
                        if (!is_legal(sel_op)) begin
                            resp_out   <= '0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= EXEC;
                        end
`else
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    if (is_shift(op) && (cnt != '0)) begin
                        acc <= shift_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == SHAMT_W'(1)) begin
                            resp_out   <= shift_nxt;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else begin
                        // Covers logical ops, illegal ops and a zero shift amount.
                        resp_out   <= is_shift(op) ? acc : logic_res;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
